// File: rtl/alu_pkg.sv
// Shared types for the iterative ALU: op encodings, FSM states and op classification.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_XOR   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_AND   = 4'b0100,
        OP_SLT   = 4'b0101,
        OP_SLTU  = 4'b0110,
        OP_SLL   = 4'b0111,
        OP_SRL   = 4'b1000,
        OP_SRA   = 4'b1001,
        OP_PASSA = 4'b1111
    } aluop_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One shifter iteration: moves acc by amt bits (amt never exceeds the per-cycle step).
module alu_shift_step #(
    parameter int XLEN = 32,
    parameter int AW   = 6
) (
    input  logic [XLEN-1:0] acc,
    input  logic [AW-1:0]   amt,
    input  logic            dir,
    input  logic            arith,
    output logic [XLEN-1:0] acc_next
);

    // dir=1 shifts right; arith selects sign fill for right shifts.
    always_comb begin
        if (!dir) begin
            acc_next = acc << amt;
        end else if (arith) begin
            acc_next = $signed(acc) >>> amt;
        end else begin
            acc_next = acc >> amt;
        end
    end

endmodule

// File: rtl/alu_iter.sv
// Handshaked RV32-style ALU: single-cycle ops register in one edge, shifts iterate
// SHIFT_STEP bits per cycle.
module alu_iter
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output state_e          dbg_state
);

    localparam int SW = $clog2(XLEN);
    localparam int CW = SW + 1;
    localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

    state_e          state_q, state_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            right_q, right_d;
    logic            arith_q, arith_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;
    logic            ready_en_q;

    logic            accept;
    logic [CW-1:0]   shamt;
    logic [CW-1:0]   step_amt;
    logic [CW-1:0]   cnt_rem;
    logic [XLEN-1:0] shifted;
    logic [XLEN:0]   calc;

    // Returns {illegal, value}. Shift ops reach here only with shamt==0, so they pass op_a.
    function automatic logic [XLEN:0] compute(input logic [3:0] f_op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [XLEN:0] r;
        r = '0;
        case (aluop_e'(f_op))
            OP_ADD:   r[XLEN-1:0] = a + b;
            OP_SUB:   r[XLEN-1:0] = a - b;
            OP_XOR:   r[XLEN-1:0] = a ^ b;
            OP_OR:    r[XLEN-1:0] = a | b;
            OP_AND:   r[XLEN-1:0] = a & b;
            OP_SLT:   r[0] = $signed(a) < $signed(b);
            OP_SLTU:  r[0] = a < b;
            OP_SLL, OP_SRL, OP_SRA, OP_PASSA: r[XLEN-1:0] = a;
            default:  r[XLEN] = 1'b1;
        endcase
        return r;
    endfunction

    // Handshake: a transfer happens on a rising edge where valid && ready; valid is held
    // until ready, and in DONE in_ready follows out_ready so a new op overlaps the drain.
    assign in_ready  = ready_en_q && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
    assign dbg_state = state_q;

    assign shamt    = {1'b0, op_b[SW-1:0]};
    assign step_amt = (cnt_q < STEP) ? cnt_q : STEP;
    assign cnt_rem  = cnt_q - step_amt;
    assign calc     = compute(op, op_a, op_b);

    alu_shift_step #(.XLEN(XLEN), .AW(CW)) u_shift (
        .acc      (acc_q),
        .amt      (step_amt),
        .dir      (right_q),
        .arith    (arith_q),
        .acc_next (shifted)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        right_d   = right_q;
        arith_d   = arith_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;

        case (state_q)
            SHIFT: begin
                acc_d = shifted;
                cnt_d = cnt_rem;
                if (cnt_rem == '0) begin
                    result_d  = shifted;
                    zero_d    = (shifted == '0);
                    illegal_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready && !accept) state_d = IDLE;
            end
            default: ;
        endcase

        if (accept) begin
            if (is_shift(op) && (shamt != '0)) begin
                acc_d   = op_a;
                cnt_d   = shamt;
                right_d = (op != OP_SLL);
                arith_d = (op == OP_SRA);
                state_d = SHIFT;
            end else begin
                result_d  = calc[XLEN-1:0];
                illegal_d = calc[XLEN];
                zero_d    = (calc[XLEN-1:0] == '0);
                state_d   = DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            right_q    <= 1'b0;
            arith_q    <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            illegal_q  <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            right_q    <= right_d;
            arith_q    <= arith_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            illegal_q  <= illegal_d;
            ready_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter: one instance with SHIFT_STEP=1, one with SHIFT_STEP=4.
module tb_alu_iter;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sel = 1'b0;
    logic         in_valid = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         out_ready = 1'b1;

    logic         rdy1, rdy4, ov1, ov4, z1, z4, il1, il4;
    logic [W-1:0] res1, res4;
    state_e       st1, st4;

    logic         rdy, ov, zr, il;
    logic [W-1:0] res;
    state_e       st;

    logic [W-1:0] exp_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;

    always #5 clk = ~clk;

    alu_iter #(.XLEN(W), .SHIFT_STEP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !sel), .in_ready(rdy1),
        .op(op), .op_a(op_a), .op_b(op_b), .out_valid(ov1), .out_ready(out_ready),
        .result(res1), .zero(z1), .illegal(il1), .dbg_state(st1)
    );

    alu_iter #(.XLEN(W), .SHIFT_STEP(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel), .in_ready(rdy4),
        .op(op), .op_a(op_a), .op_b(op_b), .out_valid(ov4), .out_ready(out_ready),
        .result(res4), .zero(z4), .illegal(il4), .dbg_state(st4)
    );

    assign rdy = sel ? rdy4 : rdy1;
    assign ov  = sel ? ov4  : ov1;
    assign zr  = sel ? z4   : z1;
    assign il  = sel ? il4  : il1;
    assign res = sel ? res4 : res1;
    assign st  = sel ? st4  : st1;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Presents one op, scrambles operands after the accept edge and checks the outcome.
    task automatic run_op(input string tag, input logic [3:0] f_op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res,
                          input logic exp_ill, input int exp_lat);
        int  guard;
        int  lat;
        logic rdy_bad;
        @(negedge clk);
        in_valid = 1'b1;
        op = f_op;
        op_a = a;
        op_b = b;
        exp_q.push_back(exp_res);
        guard = 0;
        while (!rdy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_accept_timeout"}, W'(guard >= 100), '0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        op = 4'($urandom_range(0, 15));
        lat = 1;
        rdy_bad = 1'b0;
        while (!ov && lat < 100) begin
            if (rdy) rdy_bad = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, W'(lat), W'(exp_lat));
        check({tag, "_result"}, res, exp_q.pop_front());
        check({tag, "_zero"}, W'(zr), W'(exp_res == '0));
        check({tag, "_illegal"}, W'(il), W'(exp_ill));
        check({tag, "_ready_low_in_shift"}, W'(rdy_bad), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        logic [W-1:0] e;

        // Reset values
        #12;
        check("rst_in_ready", W'(rdy1), '0);
        check("rst_out_valid", W'(ov1), '0);
        check("rst_result", res1, '0);
        check("rst_zero", W'(z1), '0);
        check("rst_illegal", W'(il1), '0);
        check("rst_state", W'(st1), W'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", W'(rdy1), 32'd1);

        out_ready = 1'b1;
        sel = 1'b0;
        run_op("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1);
        run_op("slt", 4'b0101, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1);
        run_op("sltu", 4'b0110, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1);
        run_op("sub", 4'b0001, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
        run_op("xor", 4'b0010, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1'b0, 1);
        run_op("or", 4'b0011, 32'hA000_0005, 32'h0000_0F00, 32'hA000_0F05, 1'b0, 1);
        run_op("and", 4'b0100, 32'hA5A5_A5A5, 32'h0FF0_0FF0, 32'h05A0_05A0, 1'b0, 1);
        run_op("passa", 4'b1111, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 1);
        run_op("illegal", 4'b1010, 32'h1234_5678, 32'h1, 32'h0, 1'b1, 1);

        run_op("sra31_s1", 4'b1001, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 32);
        run_op("srl31_s1", 4'b1000, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, 32);

        sel = 1'b1;
        run_op("sll5_s4", 4'b0111, 32'h1, 32'h25, 32'h20, 1'b0, 3);
        run_op("sll0_s4", 4'b0111, 32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF, 1'b0, 1);
        run_op("sra31_s4", 4'b1001, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 9);
        sel = 1'b0;

        // Back-pressure: result held while out_ready is low
        out_ready = 1'b0;
        run_op("hold_add", 4'b0000, 32'd3, 32'd4, 32'd7, 1'b0, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            op = 4'b0000;
            check("hold_out_valid", W'(ov), 32'd1);
            check("hold_result", res, 32'd7);
            check("hold_in_ready", W'(rdy), '0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("drain_out_valid", W'(ov), '0);

        // Back-to-back ADDs: one result per cycle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            op = 4'b0000;
            op_a = 32'h100 * (i + 1);
            op_b = 32'd3 + i;
            exp_q.push_back(32'h100 * (i + 1) + 32'd3 + i);
            @(posedge clk);
            #1;
            check("b2b_out_valid", W'(ov), 32'd1);
            check("b2b_result", res, exp_q.pop_front());
        end
        @(negedge clk);
        in_valid = 1'b0;

        // Reset in the middle of a shift drops the op immediately
        @(negedge clk);
        in_valid = 1'b1;
        op = 4'b1000;
        op_a = 32'hF000_0000;
        op_b = 32'd20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_shift_state", W'(st), W'(SHIFT));
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", W'(ov), '0);
        check("mid_rst_result", res, '0);
        check("mid_rst_state", W'(st), W'(IDLE));
        check("mid_rst_in_ready", W'(rdy), '0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ov) seen = 1'b1;
        end
        check("no_stale_output", W'(seen), '0);

        e = 32'h0;
        check("queue_empty", W'(exp_q.size()), e);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
